// File: rtl/qerv_rf_ram_bridge.sv
// Bit-serial register-file streams to word-wide simple-dual-port SRAM bridge.
// Two read ports are fetched per word period; two write ports are assembled and written back-to-back.
module qerv_rf_ram_bridge #(
  parameter int width    = 8,
  parameter int bpc      = 1,
  parameter int csr_regs = 4,
  parameter int x0_guard = 1,
  parameter int raw      = $clog2(32 + csr_regs),
  parameter int aw       = raw + $clog2(32 / width)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_ready,
  output logic             o_busy,
  input  logic [raw-1:0]   i_rreg0,
  input  logic [raw-1:0]   i_rreg1,
  input  logic [raw-1:0]   i_wreg0,
  input  logic [raw-1:0]   i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic [bpc-1:0]   i_wdata0,
  input  logic [bpc-1:0]   i_wdata1,
  output logic [bpc-1:0]   o_rdata0,
  output logic [bpc-1:0]   o_rdata1,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);
  localparam int S   = 32 / bpc;
  localparam int P   = width / bpc;
  localparam int LP  = $clog2(P);
  localparam int WB  = $clog2(32 / width);
  localparam int WBX = (WB > 0) ? WB : 1;
  localparam int CW  = $clog2(S + 4);

  localparam logic [CW-1:0] S_C = CW'(S);

  logic          busy_q, busy_d, wr_q, wr_d, rgrant_q, rgrant_d;
  logic          wstb0_q, wstb0_d, wstb1_q, wstb1_d;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic [1:0]    wcap_q, wcap_d, wenb_q, wenb_d;
  logic [width-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
  logic [width-1:0] asm0_q, asm0_d, asm1_q, asm1_d;
  logic [width-1:0] wbuf0_q, wbuf0_d, wbuf1_q, wbuf1_d;
  logic [WBX-1:0]   wword_q, wword_d;

  logic          req, rd_act, wr_act, ren0, ren1, win, first1, sample, cap, copy, ok0, ok1;
  logic [CW-1:0] t, b1;
  logic [raw-1:0] rsel, wsel;

  always_comb begin
    req    = i_wreq | i_rreq;
    rd_act = busy_q & ~wr_q;
    wr_act = busy_q & wr_q;
    // t: beat/fetch index relative to cycle 1; b1: output beat index (cycle 3 = beat 0)
    t      = cnt_q - CW'(1);
    b1     = cnt_q - CW'(3);
    ren0   = rd_act && (t < S_C) && (t[LP-1:0] == '0);
    ren1   = rd_act && (t < S_C) && (t[LP-1:0] == LP'(1));
    win    = rd_act && (cnt_q >= CW'(3)) && (b1 < S_C);
    first1 = win && (b1[LP-1:0] == '0);
    sample = wr_act && (t < S_C);
    cap    = sample && (t[LP-1:0] == '0);
    copy   = wr_act && (t != '0) && (t <= S_C) && (t[LP-1:0] == '0);
    last   = wr_q ? CW'(S + 3) : CW'(S + 2);

    busy_d = busy_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (req) begin
      busy_d = 1'b1;
      wr_d   = i_wreq;
      cnt_d  = CW'(1);
    end else if (busy_q) begin
      if (cnt_q == last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    rgrant_d = !req && rd_act && (cnt_q == CW'(1));
    wstb0_d  = !req && copy;
    wstb1_d  = !req && wstb0_q;
    wcap_d   = cap  ? {i_wen1, i_wen0} : wcap_q;
    wenb_d   = copy ? wcap_q : wenb_q;

    // rreg0 word lands during the rreg1 fetch cycle; rreg1 word is forwarded on its first beat
    sr0_d   = ren1   ? i_rdata : (sr0_q >> bpc);
    sr1_d   = first1 ? (i_rdata >> bpc) : (sr1_q >> bpc);
    asm0_d  = sample ? {i_wdata0, asm0_q[width-1:bpc]} : asm0_q;
    asm1_d  = sample ? {i_wdata1, asm1_q[width-1:bpc]} : asm1_q;
    wbuf0_d = copy ? asm0_q : wbuf0_q;
    wbuf1_d = copy ? asm1_q : wbuf1_q;
    wword_d = copy ? (t[LP +: WBX] - WBX'(1)) : wword_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      rgrant_q <= 1'b0;
      wstb0_q  <= 1'b0;
      wstb1_q  <= 1'b0;
      wcap_q   <= '0;
      wenb_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      rgrant_q <= rgrant_d;
      wstb0_q  <= wstb0_d;
      wstb1_q  <= wstb1_d;
      wcap_q   <= wcap_d;
      wenb_q   <= wenb_d;
    end
  end

  always_ff @(posedge i_clk) begin
    sr0_q   <= sr0_d;
    sr1_q   <= sr1_d;
    asm0_q  <= asm0_d;
    asm1_q  <= asm1_d;
    wbuf0_q <= wbuf0_d;
    wbuf1_q <= wbuf1_d;
    wword_q <= wword_d;
  end

  assign ok0 = !((x0_guard != 0) && (i_wreg0 == '0));
  assign ok1 = !((x0_guard != 0) && (i_wreg1 == '0));
  assign rsel = ren1 ? i_rreg1 : i_rreg0;
  assign wsel = wstb1_q ? i_wreg1 : i_wreg0;

  generate
    if (WB == 0) begin : g_noword
      assign o_raddr = rsel;
      assign o_waddr = wsel;
    end else begin : g_word
      assign o_raddr = {rsel, t[LP +: WB]};
      assign o_waddr = {wsel, wword_q[WB-1:0]};
    end
  endgenerate

  assign o_ren    = ren0 | ren1;
  assign o_wen    = (wstb0_q & wenb_q[0] & ok0) | (wstb1_q & wenb_q[1] & ok1);
  assign o_wdata  = wstb1_q ? wbuf1_q : wbuf0_q;
  assign o_rdata0 = win ? sr0_q[bpc-1:0] : '0;
  assign o_rdata1 = win ? (first1 ? i_rdata[bpc-1:0] : sr1_q[bpc-1:0]) : '0;
  assign o_ready  = i_wreq | rgrant_q;
  assign o_busy   = busy_q;
endmodule

// File: tb/tb_qerv_rf_ram_bridge.sv
// Directed bench: an 8-bit/2-bpc bridge and a 32-bit/1-bpc bridge, each backed by a small SRAM model.
module tb_qerv_rf_ram_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b0;
  int   nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  // dut_a: width 8, bpc 2 (raw 6, aw 8)
  logic       a_rreq = 0, a_wreq = 0, a_ready, a_busy, a_wen0 = 0, a_wen1 = 0, a_wen, a_ren;
  logic [5:0] a_rreg0 = 0, a_rreg1 = 0, a_wreg0 = 0, a_wreg1 = 0;
  logic [1:0] a_wd0 = 0, a_wd1 = 0, a_rd0, a_rd1;
  logic [7:0] a_waddr, a_raddr, a_wdata, a_rdata;
  logic [7:0] mem_a [256];

  // dut_b: width 32, bpc 1 (raw 6, aw 6)
  logic        b_rreq = 0, b_ready, b_busy, b_wen, b_ren, b_rd0, b_rd1;
  logic [5:0]  b_rreg0 = 0, b_rreg1 = 0, b_waddr, b_raddr;
  logic [31:0] b_wdata, b_rdata;
  logic [31:0] mem_b [64];

  qerv_rf_ram_bridge #(.width(8), .bpc(2), .csr_regs(4), .x0_guard(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(a_rreq), .i_wreq(a_wreq),
    .o_ready(a_ready), .o_busy(a_busy),
    .i_rreg0(a_rreg0), .i_rreg1(a_rreg1), .i_wreg0(a_wreg0), .i_wreg1(a_wreg1),
    .i_wen0(a_wen0), .i_wen1(a_wen1), .i_wdata0(a_wd0), .i_wdata1(a_wd1),
    .o_rdata0(a_rd0), .o_rdata1(a_rd1),
    .o_waddr(a_waddr), .o_wdata(a_wdata), .o_wen(a_wen),
    .o_raddr(a_raddr), .o_ren(a_ren), .i_rdata(a_rdata));

  qerv_rf_ram_bridge #(.width(32), .bpc(1), .csr_regs(4), .x0_guard(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(b_rreq), .i_wreq(1'b0),
    .o_ready(b_ready), .o_busy(b_busy),
    .i_rreg0(b_rreg0), .i_rreg1(b_rreg1), .i_wreg0(6'd0), .i_wreg1(6'd0),
    .i_wen0(1'b0), .i_wen1(1'b0), .i_wdata0(1'b0), .i_wdata1(1'b0),
    .o_rdata0(b_rd0), .o_rdata1(b_rd1),
    .o_waddr(b_waddr), .o_wdata(b_wdata), .o_wen(b_wen),
    .o_raddr(b_raddr), .o_ren(b_ren), .i_rdata(b_rdata));

  // SRAM models: write on strobe, read data registered one cycle after o_ren
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
      for (int i = 0; i < 64; i++) mem_b[i] <= 32'h0;
      mem_b[1] <= 32'h8000_0001;
      mem_b[2] <= 32'h0000_0003;
    end else begin
      if (a_wen) mem_a[a_waddr] <= a_wdata;
      if (b_wen) mem_b[b_waddr] <= b_wdata;
    end
    if (a_ren) a_rdata <= mem_a[a_raddr];
    if (b_ren) b_rdata <= mem_b[b_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write sequence on dut_a; x0/x1 say which ports are expected to reach the SRAM.
  task automatic a_write(input logic [5:0] r0, input logic [5:0] r1, input logic e0, input logic e1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic x0, input logic x1);
    logic p0, p1;
    int   j;
    @(negedge clk);
    a_wreg0 = r0; a_wreg1 = r1; a_wen0 = e0; a_wen1 = e1; a_wreq = 1'b1;
    #1 chk("wr_ready_c0", 32'(a_ready), 32'd1);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      a_wreq = 1'b0;
      chk("wr_busy", 32'(a_busy), 32'(c <= 19));
      p0 = x0 && c >= 6 && c <= 18 && ((c - 6) % 4 == 0);
      p1 = x1 && c >= 7 && c <= 19 && ((c - 7) % 4 == 0);
      chk("wr_wen", 32'(a_wen), 32'(p0 | p1));
      if (p0) begin
        j = (c - 6) / 4;
        chk("wr_addr0", 32'(a_waddr), 32'({r0, 2'(j)}));
        chk("wr_data0", 32'(a_wdata), 32'(d0[8*j +: 8]));
      end
      if (p1) begin
        j = (c - 7) / 4;
        chk("wr_addr1", 32'(a_waddr), 32'({r1, 2'(j)}));
        chk("wr_data1", 32'(a_wdata), 32'(d1[8*j +: 8]));
      end
      if (c <= 16) begin
        a_wd0 = d0[2*(c-1) +: 2];
        a_wd1 = d1[2*(c-1) +: 2];
      end
    end
    a_wen0 = 1'b0; a_wen1 = 1'b0;
  endtask

  task automatic a_read(input logic [5:0] r0, input logic [5:0] r1,
                        input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    a_rreg0 = r0; a_rreg1 = r1; a_rreq = 1'b1;
    #1 chk("rd_ready_c0", 32'(a_ready), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      a_rreq = 1'b0;
      chk("rd_ready", 32'(a_ready), 32'(c == 2));
      chk("rd_busy", 32'(a_busy), 32'(c <= 18));
      if (c >= 3 && c <= 18) begin
        chk("rd_data0", 32'(a_rd0), 32'(e0[2*(c-3) +: 2]));
        chk("rd_data1", 32'(a_rd1), 32'(e1[2*(c-3) +: 2]));
      end else begin
        chk("rd_idle0", 32'(a_rd0), 32'd0);
        chk("rd_idle1", 32'(a_rd1), 32'd0);
      end
    end
  endtask

  initial begin
    int nren;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_wen", 32'(a_wen), 32'd0);
    chk("rst_ren", 32'(a_ren), 32'd0);
    chk("rst_rdata", 32'({a_rd0, a_rd1}), 32'd0);
    rst_n = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(negedge clk);

    // Port-0 write of x5, then read back through both ports
    a_write(6'd5, 6'd3, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    chk("mem_x5_w3", 32'(mem_a[{6'd5, 2'd3}]), 32'hDE);
    a_read(6'd5, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // x0 write is dropped; x7 on port 1 lands
    a_write(6'd0, 6'd7, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    a_read(6'd0, 6'd7, 32'h0, 32'hFFFF_FFFF);

    // Same-register collision: port 1 is written last
    a_write(6'd9, 6'd9, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1);
    a_read(6'd9, 6'd9, 32'h2222_2222, 32'h2222_2222);

    // 32-bit word, 1 bit per cycle: one fetch per register
    nren = 0;
    @(negedge clk);
    b_rreg0 = 6'd1; b_rreg1 = 6'd2; b_rreq = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      b_rreq = 1'b0;
      if (b_ren) begin
        nren++;
        chk("b_raddr", 32'(b_raddr), (c == 1) ? 32'd1 : 32'd2);
      end
      if (c == 2) chk("b_ready", 32'(b_ready), 32'd1);
      if (c == 3) chk("b_bit0", 32'({b_rd0, b_rd1}), 32'b11);
      if (c == 34) chk("b_bit31", 32'({b_rd0, b_rd1}), 32'b10);
      if (c >= 3 && c <= 34) begin
        chk("b_data0", 32'(b_rd0), 32'(32'h8000_0001 >> (c - 3)) & 32'd1);
        chk("b_data1", 32'(b_rd1), 32'(32'h0000_0003 >> (c - 3)) & 32'd1);
      end
      if (c == 36) chk("b_busy_end", 32'(b_busy), 32'd0);
    end
    chk("b_ren_count", 32'(nren), 32'd2);

    // Reset in cycle 8 of a write: word 0 (cycle 6) stays, nothing more is written
    @(negedge clk);
    a_wreg0 = 6'd12; a_wreg1 = 6'd13; a_wen0 = 1'b1; a_wen1 = 1'b0; a_wreq = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      a_wreq = 1'b0;
      if (c == 6) chk("rst_seq_wen6", 32'(a_wen), 32'd1);
      a_wd0 = 32'h0123_4567 >> (2 * (c - 1));
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", 32'(a_wen), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nren = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_wen || a_ren) nren++;
    end
    chk("postrst_access", 32'(nren), 32'd0);
    chk("postrst_w0", 32'(mem_a[{6'd12, 2'd0}]), 32'h67);
    chk("postrst_w1", 32'(mem_a[{6'd12, 2'd1}]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
